// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: single-port byte RAM driven by 10-bit command words from an SPI slave
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   din      : command word, [9:8] opcode, [7:0] payload
//   rx_valid : word valid; a rising level is one command
//   dout     : read byte toward the slave tx_data
//   tx_valid : dout holds a valid read byte
//   cmd_err  : one-cycle pulse after a rejected command
//   busy     : high in the cycle between RD_DATA acceptance and the dout update
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err,
    output logic       busy
);
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RD_PEND, HOLD} state_t;

    state_t                 r_state, w_next;
    logic                   r_rx_q;
    logic [ADDR_SIZE-1:0]   r_wr_addr, r_rd_addr;
    logic                   r_wr_vld, r_rd_vld;
    logic [7:0]             r_mem [MEM_DEPTH];
    logic [7:0]             r_rd_q;
    logic [7:0]             r_dout;
    logic                   r_err;

    logic                   w_acc;
    logic [1:0]             w_op;
    logic [ADDR_SIZE-1:0]   w_addr_in;
    logic                   w_oob;
    logic                   w_wa_ok, w_ra_ok, w_wr_ok, w_rd_ok, w_err;
    logic [ADDR_SIZE-1:0]   w_wr_next, w_rd_next;

    // a command is the first cycle of a high rx_valid level
    assign w_acc     = rst_n & rx_valid & ~r_rx_q;
    assign w_op      = din[9:8];
    assign w_addr_in = din[ADDR_SIZE-1:0];
    assign w_oob     = 32'(w_addr_in) >= 32'(MEM_DEPTH);

    assign w_wa_ok = w_acc & (w_op == WR_ADDR) & ~w_oob;
    assign w_ra_ok = w_acc & (w_op == RD_ADDR) & ~w_oob;
    assign w_wr_ok = w_acc & (w_op == WR_DATA) & r_wr_vld;
    assign w_rd_ok = w_acc & (w_op == RD_DATA) & r_rd_vld;
    assign w_err   = w_acc & ~(w_wa_ok | w_ra_ok | w_wr_ok | w_rd_ok);

    // wrap at MEM_DEPTH-1 so non-power-of-2 depths stay in range
    assign w_wr_next = (r_wr_addr == LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
    assign w_rd_next = (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_q    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_wr_vld  <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_dout    <= 8'h00;
        end else begin
            r_rx_q <= rx_valid;
            r_err  <= w_err;
            if (w_wa_ok) begin
                r_wr_addr <= w_addr_in;
                r_wr_vld  <= 1'b1;
            end else if (w_wr_ok && AUTO_INC) begin
                r_wr_addr <= w_wr_next;
            end
            if (w_ra_ok) begin
                r_rd_addr <= w_addr_in;
                r_rd_vld  <= 1'b1;
            end else if (w_rd_ok && AUTO_INC) begin
                r_rd_addr <= w_rd_next;
            end
            if (r_state == RD_PEND)
                r_dout <= r_rd_q;
        end
    end

    // storage is not reset; writes are already blocked while rst_n is low
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[r_wr_addr] <= din[7:0];
        if (w_rd_ok)
            r_rd_q <= r_mem[r_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        tx_valid = 1'b0;
        unique case (r_state)
            IDLE:    w_next = w_rd_ok ? RD_PEND : IDLE;
            RD_PEND: begin
                w_next = HOLD;
                busy   = 1'b1;
            end
            HOLD:    begin
                w_next   = w_rd_ok ? RD_PEND : (w_acc ? IDLE : HOLD);
                tx_valid = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    assign dout    = r_dout;
    assign cmd_err = r_err;
endmodule
